perf_stats_accumulator: RTL and testbench

- Sits directly downstream of the performance counter on a monitored stream.
- Detects completion of each measured transfer and captures the counter's final cycles/idle_cycles values.
- Accumulates count, sum, min and max over a window.
- Emits the window summary as a single valid/ready report beat, either on request or automatically every REPORT_EVERY samples.

---
 rtl/perf_stats_accumulator_pkg.sv | 31 +++
 rtl/perf_stats_window.sv | 85 ++++++++
 rtl/perf_stats_accumulator.sv | 125 ++++++++++++
 tb/tb_perf_stats_accumulator.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_stats_accumulator_pkg.sv
// Shared types for the performance-counter statistics path: 64-bit data word,
// the window summary record, the reporting FSM states and a saturating adder.
package perf_stats_accumulator_pkg;

  typedef logic [63:0] data64_t;

  localparam data64_t DATA64_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  // Window summary; count is carried at full width, upper bits beyond the
  // configured counter width are always zero.
  typedef struct packed {
    data64_t count;
    data64_t sum_cycles;
    data64_t sum_idle;
    data64_t min_cycles;
    data64_t max_cycles;
  } report_t;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  // 64-bit add that pins at all-ones instead of wrapping.
  function automatic data64_t SAT_ADD64(input data64_t a, input data64_t b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[64] ? DATA64_ONES : s[63:0];
  endfunction

endpackage

// File: rtl/perf_stats_window.sv
// Accumulator datapath for one statistics window. acc_next_o is the window
// with the current sample folded in, regardless of clear/close, so the
// controller can snapshot it on the closing edge.
module perf_stats_window
  import perf_stats_accumulator_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_i,
  input  logic             clear_i,
  input  logic             close_i,
  input  data64_t          cycles_i,
  input  data64_t          idle_i,
  output logic [CNT_W-1:0] count_next_o,
  output report_t          acc_next_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d, count_upd;
  data64_t          sum_cyc_q, sum_cyc_d, sum_cyc_upd;
  data64_t          sum_idle_q, sum_idle_d, sum_idle_upd;
  data64_t          min_q, min_d, min_upd;
  data64_t          max_q, max_d, max_upd;

  // Fold the current sample into the running statistics.
  always_comb begin
    count_upd    = count_q;
    sum_cyc_upd  = sum_cyc_q;
    sum_idle_upd = sum_idle_q;
    min_upd      = min_q;
    max_upd      = max_q;
    if (sample_i) begin
      count_upd    = (count_q == '1) ? count_q : count_q + CNT_ONE;
      sum_cyc_upd  = SAT_ADD64(sum_cyc_q, cycles_i);
      sum_idle_upd = SAT_ADD64(sum_idle_q, idle_i);
      min_upd      = (cycles_i < min_q) ? cycles_i : min_q;
      max_upd      = (cycles_i > max_q) ? cycles_i : max_q;
    end
  end

  // Clear drops any coincident sample; close restarts the window after the
  // snapshot has been taken from acc_next_o.
  always_comb begin
    count_d    = count_upd;
    sum_cyc_d  = sum_cyc_upd;
    sum_idle_d = sum_idle_upd;
    min_d      = min_upd;
    max_d      = max_upd;
    if (clear_i || close_i) begin
      count_d    = '0;
      sum_cyc_d  = '0;
      sum_idle_d = '0;
      min_d      = DATA64_ONES;
      max_d      = '0;
    end
  end

  // Accumulator registers; min starts at all-ones so the first sample wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      sum_cyc_q  <= '0;
      sum_idle_q <= '0;
      min_q      <= DATA64_ONES;
      max_q      <= '0;
    end else begin
      count_q    <= count_d;
      sum_cyc_q  <= sum_cyc_d;
      sum_idle_q <= sum_idle_d;
      min_q      <= min_d;
      max_q      <= max_d;
    end
  end

  assign count_next_o = count_upd;
  assign acc_next_o   = '{count:      64'(count_upd),
                          sum_cycles: sum_cyc_upd,
                          sum_idle:   sum_idle_upd,
                          min_cycles: min_upd,
                          max_cycles: max_upd};

endmodule

// File: rtl/perf_stats_accumulator.sv
// Window statistics collector behind a performance counter. Captures the
// counter's final values one cycle after each last handshake, accumulates
// them, and presents the window summary as a single valid/ready beat.
//
// state  | meaning
// ACCUM  | collecting samples, no report presented
// REPORT | summary beat presented, waiting for report_ready; sampling goes on
module perf_stats_accumulator
  import perf_stats_accumulator_pkg::*;
#(
  parameter int REPORT_EVERY = 0,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             is_handshake,
  input  logic             is_last,
  input  logic [63:0]      cycles,
  input  logic [63:0]      idle_cycles,
  input  logic             clear,
  input  logic             report_req,
  output logic             report_valid,
  input  logic             report_ready,
  output logic [CNT_W-1:0] report_count,
  output logic [63:0]      report_sum_cycles,
  output logic [63:0]      report_sum_idle,
  output logic [63:0]      report_min_cycles,
  output logic [63:0]      report_max_cycles
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(REPORT_EVERY);

  logic             done_q;
  state_t           state_q, state_d;
  logic             pending_q, pending_d;
  report_t          rep_q, rep_d;
  logic             close;
  logic             auto_hit;
  logic [CNT_W-1:0] count_next;
  report_t          acc_next;

  // The counter register settles on the last-handshake edge, so its outputs
  // are valid to capture one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= is_handshake && is_last;
    end
  end

  perf_stats_window #(
    .CNT_W (CNT_W)
  ) u_window (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_i     (done_q),
    .clear_i      (clear),
    .close_i      (close),
    .cycles_i     (cycles),
    .idle_i       (idle_cycles),
    .count_next_o (count_next),
    .acc_next_o   (acc_next)
  );

  // Count advances by one per sample, so equality catches every crossing.
  assign auto_hit = (REPORT_EVERY != 0) && (count_next == THRESH);

  // Close/report sequencing; requests arriving while a beat is presented are
  // parked in pending and serviced on the first ACCUM cycle.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    rep_d     = rep_q;
    close     = 1'b0;
    case (state_q)
      ACCUM: begin
        if (!clear && (report_req || pending_q || auto_hit)) begin
          close     = 1'b1;
          rep_d     = acc_next;
          state_d   = REPORT;
          pending_d = 1'b0;
        end
      end
      REPORT: begin
        if (report_ready) begin
          state_d = ACCUM;
        end
        if (!clear && (report_req || auto_hit)) begin
          pending_d = 1'b1;
        end
      end
      default: state_d = ACCUM;
    endcase
    if (clear) begin
      pending_d = 1'b0;
    end
  end

  // FSM, pending flag and the held report beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      pending_q <= 1'b0;
      rep_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rep_q     <= rep_d;
    end
  end

  // Upper count bits are zero by construction; folded here so every bit of
  // the report register has a reader.
  logic unused_count_bits;
  assign unused_count_bits = ^rep_q.count;

  assign report_valid      = (state_q == REPORT);
  assign report_count      = rep_q.count[CNT_W-1:0];
  assign report_sum_cycles = rep_q.sum_cycles;
  assign report_sum_idle   = rep_q.sum_idle;
  assign report_min_cycles = rep_q.min_cycles;
  assign report_max_cycles = rep_q.max_cycles;

endmodule

// File: tb/tb_perf_stats_accumulator.sv
// Bench for perf_stats_accumulator: a request-only instance and an
// auto-report-every-2 instance share stimulus; a sample-list reference model
// predicts every report beat.
module tb_perf_stats_accumulator;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] BIG  = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        is_handshake = 1'b0;
  logic        is_last = 1'b0;
  logic        clear = 1'b0;
  logic        report_req = 1'b0;
  logic        report_ready = 1'b0;
  logic [63:0] cycles = '0;
  logic [63:0] idle_cycles = '0;

  logic        r_valid [2];
  logic [31:0] r_cnt   [2];
  logic [63:0] r_sum   [2];
  logic [63:0] r_idle  [2];
  logic [63:0] r_min   [2];
  logic [63:0] r_max   [2];

  always #5 clk = ~clk;

  perf_stats_accumulator #(.REPORT_EVERY(0), .CNT_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .is_handshake(is_handshake), .is_last(is_last),
    .cycles(cycles), .idle_cycles(idle_cycles), .clear(clear),
    .report_req(report_req), .report_valid(r_valid[0]), .report_ready(report_ready),
    .report_count(r_cnt[0]), .report_sum_cycles(r_sum[0]), .report_sum_idle(r_idle[0]),
    .report_min_cycles(r_min[0]), .report_max_cycles(r_max[0]));

  perf_stats_accumulator #(.REPORT_EVERY(2), .CNT_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .is_handshake(is_handshake), .is_last(is_last),
    .cycles(cycles), .idle_cycles(idle_cycles), .clear(clear),
    .report_req(report_req), .report_valid(r_valid[1]), .report_ready(report_ready),
    .report_count(r_cnt[1]), .report_sum_cycles(r_sum[1]), .report_sum_idle(r_idle[1]),
    .report_min_cycles(r_min[1]), .report_max_cycles(r_max[1]));

  int checks = 0;
  int errors = 0;

  // Reference model: every captured sample is appended to one list; each
  // instance's open window is the tail starting at ws[m].
  int          re [2] = '{0, 2};
  logic [63:0] sc [$];
  logic [63:0] si [$];
  int          ws [2];
  logic        m_rep [2];
  logic        m_pend [2];
  logic        done_m;
  logic [63:0] e_cnt [2], e_sum [2], e_idle [2], e_min [2], e_max [2];
  logic [63:0] nxt_c = '0;
  logic [63:0] nxt_i = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sc.delete();
    si.delete();
    done_m = 1'b0;
    for (int m = 0; m < 2; m++) begin
      ws[m] = 0; m_rep[m] = 1'b0; m_pend[m] = 1'b0;
      e_cnt[m] = '0; e_sum[m] = '0; e_idle[m] = '0; e_min[m] = '0; e_max[m] = '0;
    end
  endtask

  task automatic close_window(input int m);
    logic [127:0] ts, ti;
    logic [63:0]  mn, mx;
    ts = '0; ti = '0; mn = ONES; mx = '0;
    for (int k = ws[m]; k < sc.size(); k++) begin
      ts += 128'(sc[k]);
      ti += 128'(si[k]);
      if (sc[k] < mn) mn = sc[k];
      if (sc[k] > mx) mx = sc[k];
    end
    e_cnt[m]  = 64'(sc.size() - ws[m]);
    e_sum[m]  = (ts > 128'(ONES)) ? ONES : ts[63:0];
    e_idle[m] = (ti > 128'(ONES)) ? ONES : ti[63:0];
    e_min[m]  = mn;
    e_max[m]  = mx;
    ws[m] = sc.size();
  endtask

  task automatic model_step();
    logic smp;
    logic was_rep;
    logic thr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    smp = done_m;
    done_m = is_handshake && is_last;
    if (clear) begin
      ws[0] = sc.size();
      ws[1] = sc.size();
    end else if (smp) begin
      sc.push_back(cycles);
      si.push_back(idle_cycles);
    end
    for (int m = 0; m < 2; m++) begin
      was_rep = m_rep[m];
      if (clear) begin
        m_pend[m] = 1'b0;
      end else begin
        thr = (re[m] != 0) && ((sc.size() - ws[m]) >= re[m]);
        if (!was_rep) begin
          if (report_req || m_pend[m] || thr) begin
            close_window(m);
            m_rep[m] = 1'b1;
            m_pend[m] = 1'b0;
          end
        end else if (report_req || thr) begin
          m_pend[m] = 1'b1;
        end
      end
      if (was_rep && report_ready) m_rep[m] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("valid%0d", m), {63'b0, r_valid[m]}, {63'b0, m_rep[m]});
      chk($sformatf("count%0d", m), 64'(r_cnt[m]), e_cnt[m]);
      chk($sformatf("sum%0d", m),   r_sum[m],  e_sum[m]);
      chk($sformatf("idle%0d", m),  r_idle[m], e_idle[m]);
      chk($sformatf("min%0d", m),   r_min[m],  e_min[m]);
      chk($sformatf("max%0d", m),   r_max[m],  e_max[m]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // hl: last handshake this cycle with final counter values c/i, which the
  // counter presents on the following cycle.
  task automatic step(input logic hl, input logic [63:0] c, input logic [63:0] i,
                      input logic req, input logic rdy, input logic clr);
    is_handshake = hl; is_last = hl;
    cycles = nxt_c; idle_cycles = nxt_i;
    report_req = req; report_ready = rdy; clear = clr;
    if (hl) begin nxt_c = c; nxt_i = i; end
    tick();
  endtask

  task automatic chk_rep(input string tag, input int m, input logic [63:0] cnt,
                         input logic [63:0] sum, input logic [63:0] mn, input logic [63:0] mx);
    chk({tag, "_valid"}, {63'b0, r_valid[m]}, 64'd1);
    chk({tag, "_count"}, 64'(r_cnt[m]), cnt);
    chk({tag, "_sum"}, r_sum[m], sum);
    chk({tag, "_min"}, r_min[m], mn);
    chk({tag, "_max"}, r_max[m], mx);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    is_handshake = 0; is_last = 0; clear = 0; report_req = 0; report_ready = 0;
    cycles = '0; idle_cycles = '0; nxt_c = '0; nxt_i = '0;
    #1;
    model_reset();
    check_all();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Three samples then a request; the last sample lands with the request.
    step(1, 10, 2, 0, 1, 0);
    step(1, 4, 0, 0, 1, 0);
    step(1, 7, 1, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    chk_rep("basic", 0, 3, 21, 4, 10);
    chk("basic_idle", r_idle[0], 64'd3);
    step(0, 0, 0, 0, 1, 0);
    chk("basic_accept", {63'b0, r_valid[0]}, 64'd0);
    step(0, 0, 0, 1, 1, 0);
    chk_rep("empty_after", 0, 0, 0, ONES, 0);
    step(0, 0, 0, 0, 1, 0);

    // Auto report every 2 samples with back-pressure.
    do_reset();
    step(1, 5, 0, 0, 0, 0);
    step(1, 6, 0, 0, 0, 0);
    step(1, 9, 0, 0, 0, 0);
    chk_rep("auto1", 1, 2, 11, 5, 6);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk_rep("auto1_hold", 1, 2, 11, 5, 6);
    step(0, 0, 0, 0, 1, 0);
    chk("auto1_accept", {63'b0, r_valid[1]}, 64'd0);
    step(1, 8, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk_rep("auto2", 1, 2, 17, 8, 9);
    step(0, 0, 0, 0, 1, 0);

    // Request while a beat is held becomes pending; merged repeats.
    do_reset();
    step(1, 3, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk_rep("pend_first", 0, 1, 3, 3, 3);
    step(1, 5, 0, 1, 0, 0);
    step(1, 6, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("pend_accept", {63'b0, r_valid[0]}, 64'd0);
    step(0, 0, 0, 0, 0, 0);
    chk_rep("pend_second", 0, 2, 11, 5, 6);
    step(0, 0, 0, 0, 1, 0);

    // Saturating sum.
    do_reset();
    step(1, BIG, 0, 0, 0, 0);
    step(1, BIG, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk_rep("sat", 0, 2, ONES, BIG, BIG);
    step(0, 0, 0, 0, 1, 0);

    // Clear coincident with a sample drops it.
    do_reset();
    step(1, 5, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    chk_rep("clr", 0, 0, 0, ONES, 0);

    // Asynchronous reset while a beat is presented.
    chk("arst_pre", {63'b0, r_valid[0]}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid0", {63'b0, r_valid[0]}, 64'd0);
    chk("arst_valid1", {63'b0, r_valid[1]}, 64'd0);
    chk("arst_count0", 64'(r_cnt[0]), 64'd0);
    tick();
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      is_handshake = ($urandom_range(0, 2) == 0);
      is_last      = ($urandom_range(0, 1) == 0);
      cycles       = nxt_c;
      idle_cycles  = nxt_i;
      report_req   = ($urandom_range(0, 15) == 0);
      report_ready = ($urandom_range(0, 1) == 0);
      clear        = ($urandom_range(0, 63) == 0);
      if (is_handshake && is_last) begin
        if ($urandom_range(0, 15) == 0) nxt_c = {$urandom, $urandom};
        else nxt_c = 64'($urandom_range(0, 200));
        nxt_i = 64'($urandom_range(0, 50));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
